// File: rtl/instruction_ram_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words and writes them to
// instruction RAM from address 0 upward, stalling the CPU until the last word is written.
module instruction_ram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   programLength,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  cpuHold,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = programLength;
          if (programLength == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d  = '0;
            cnt_d   = '0;
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (byteValid) begin
          word_d = {word_q[DATA_WIDTH-9:0], byteIn};
          cnt_d  = cnt_q + 2'd1;
          // Write-port registers latch here so they stay stable while the next word assembles.
          if (cnt_q == 2'd3) begin
            waddr_d = addr_q;
            wdata_d = {word_q[DATA_WIDTH-9:0], byteIn};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if ({1'b0, addr_q} == len_q - (ADDR_WIDTH+1)'(1)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign byteReady    = (state_q == S_COLLECT);
  assign writeEnable  = (state_q == S_WRITE);
  assign writeAddress = waddr_q;
  assign writeData    = wdata_q;
  assign cpuHold      = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: doc/instruction_ram_loader.md
# instruction_ram_loader

Boot-time writer for the processor's instruction memory. Accepts the program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word into consecutive instruction-RAM addresses starting at 0. It holds the CPU in reset-equivalent stall while loading, replacing the hard-coded first-clock initialisation of instruction memory with a runtime load path.

## Interface

Parameters:
- ADDR_WIDTH, 10: instruction-RAM address width; matches the 10-bit instruction fetch address.
- DATA_WIDTH, 32: instruction word width; fixed at 32, so a word is four bytes.

Ports:
- clock  input  1  single system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level sampled in IDLE; begins a load.
- programLength  input  ADDR_WIDTH+1  number of words to load (0..2^ADDR_WIDTH); sampled when start is accepted.
- byteIn  input  8  stream byte, most significant byte of each word first.
- byteValid  input  1  byteIn is valid.
- byteReady  output  1  loader can accept a byte this cycle.
- writeEnable  output  1  one-cycle instruction-RAM write strobe.
- writeAddress  output  ADDR_WIDTH  word address for the write.
- writeData  output  32  assembled instruction word.
- cpuHold  output  1  stall request to the processor while a load is in progress.
- done  output  1  one-cycle pulse when the last word has been written.

## Operation

- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byteReady=0, cpuHold=0. If start=1: latch programLength; if latched length is 0, go to DONE; otherwise clear word address and byte counter, go to COLLECT.
- COLLECT: byteReady=1, cpuHold=1. A byte is accepted on a posedge where byteValid&byteReady. Each accepted byte shifts into the word register: word <= {word[23:0], byteIn}. Byte counter (2 bits) increments per accepted byte; on acceptance of the 4th byte, go to WRITE. byteValid=0 cycles stall without side effects.
- WRITE: byteReady=0, writeEnable=1, writeData=assembled word, writeAddress=current address. Next: if address == length-1, go to DONE; else address+1, byte counter 0, go to COLLECT.
- DONE: done=1, cpuHold=1 for exactly this cycle; next state IDLE.
- start is ignored in every state except IDLE.
- Bytes offered while byteReady=0 are not consumed; the source must hold them.
- Length 2^ADDR_WIDTH (1024): last write at address 1023; the address never wraps because DONE is taken first.
- writeAddress and writeData hold their last values outside WRITE; only writeEnable qualifies them.

## Timing

- Reset (reset=0, asynchronous): state IDLE; byteReady=0, writeEnable=0, writeAddress=0, writeData=0, cpuHold=0, done=0; byte counter, address, latched length cleared. A partial word in progress is discarded; no write is issued.
- start sampled on posedge in IDLE; byteReady=1 from the following cycle.
- writeEnable asserts in the cycle immediately after the posedge accepting the 4th byte of a word.
- Minimum throughput: 5 cycles per word (4 byte cycles + 1 write cycle), byteReady=0 during the write cycle.
- done asserts the cycle after the final write cycle; IDLE the cycle after that. Total for N words at full rate: 1 (start) + 5N + 1 cycles to done.
- Length 0: done asserts the cycle after start is accepted; no write issued.
- All outputs registered or decoded from the registered state only; no combinational path from byteValid or start to any output.

## Test plan

- Single word: start, length=1, bytes 6C 00 00 00 back-to-back -> one writeEnable, writeAddress=0, writeData=0x6C000000, done one cycle later, cpuHold low after.
- Four-word program: bytes for 0x6C000000, 0x6840002D, 0x68608003, 0x90620000 -> writes at addresses 0..3 in order with those words, exactly 4 writeEnable pulses, done once.
- Stalled source: same as single word with byteValid dropped for 3 cycles between bytes 2 and 3 -> same writeData 0x6C000000, byteReady stays 1 while waiting, write delayed by 3 cycles.
- Length 0 and busy start: length=0 -> done next cycle with no write; start re-asserted during COLLECT of a length-2 load -> ignored, exactly 2 writes.
- Reset mid-word: after 2 bytes of word at address 1, pull reset low -> all outputs at reset values immediately, no write to address 1; new start, length=1, bytes 12 34 56 78 -> write 0x12345678 at address 0.
- Full depth: length=1024 with incrementing word values -> last write at address 1023, no write to address 0 after it, done once.
